gpi_debounce_core: RTL

//  MMIO slot core for external inputs (Pmod buttons/switches) beside the OLED output core.

---
 rtl/gpi_debounce_core_if.sv | 27 ++
 rtl/gpi_debounce_core.sv | 114 +++++++++++
 2 files changed

// File: rtl/gpi_debounce_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_debounce_core_if
//  Description : MMIO slot bus between the processor-side master and the
//                debounced-input core (select, strobes, address, data, irq).
//  Revision    : 1.0  initial release
// ============================================================================
interface gpi_debounce_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data, irq
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data, irq
  );
endinterface
`default_nettype wire

// File: rtl/gpi_debounce_core.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_debounce_core
//  Description : Synchronises and debounces W external inputs, latches
//                debounced rise/fall edges in write-1-to-clear registers and
//                raises a maskable level interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module gpi_debounce_core #(
  parameter int W        = 4,
  parameter int DB_TICKS = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  gpi_debounce_core_if.slave     bus,
  input  logic [W-1:0]           din
);

  localparam int                c_cnt_w   = $clog2(DB_TICKS);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_TICKS - 1);

  localparam logic [1:0] c_addr_deb  = 2'd0;
  localparam logic [1:0] c_addr_rise = 2'd1;
  localparam logic [1:0] c_addr_fall = 2'd2;
  localparam logic [1:0] c_addr_mask = 2'd3;

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] r_deb;
  logic [W-1:0] r_rise;
  logic [W-1:0] r_fall;
  logic [W-1:0] r_mask;
  logic         r_irq;

  logic [W-1:0] w_deb_upd;
  logic         w_wr;
  logic [W-1:0] w_clr_rise;
  logic [W-1:0] w_clr_fall;
  logic [31:0]  w_rd_data;
  logic         w_unused;

  // Read strobe has no side effects and upper address/data bits are not decoded.
  assign w_unused = ^{bus.read, bus.addr[4:2], bus.wr_data};

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic [c_cnt_w-1:0] r_cnt;

      // Count consecutive cycles the synchronised input differs from the
      // debounced level; any return to the old level restarts the count.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if ((r_sync2[i] == r_deb[i]) || (r_cnt == c_cnt_max)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end

      assign w_deb_upd[i] = (r_sync2[i] != r_deb[i]) && (r_cnt == c_cnt_max);
    end
  endgenerate

  assign w_wr       = bus.cs && bus.write;
  assign w_clr_rise = (w_wr && (bus.addr[1:0] == c_addr_rise)) ? bus.wr_data[W-1:0] : '0;
  assign w_clr_fall = (w_wr && (bus.addr[1:0] == c_addr_fall)) ? bus.wr_data[W-1:0] : '0;

  // Debounced level, edge latches (set beats same-cycle clear), mask and irq.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_deb  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_deb  <= r_deb ^ w_deb_upd;
      r_rise <= (r_rise & ~w_clr_rise) | (w_deb_upd & r_sync2);
      r_fall <= (r_fall & ~w_clr_fall) | (w_deb_upd & ~r_sync2);
      if (w_wr && (bus.addr[1:0] == c_addr_mask)) begin
        r_mask <= bus.wr_data[W-1:0];
      end
      r_irq  <= |((r_rise | r_fall) & r_mask);
    end
  end

  // Combinational read mux; unused upper bits read as zero.
  always_comb begin
    w_rd_data = '0;
    case (bus.addr[1:0])
      c_addr_deb:  w_rd_data[W-1:0] = r_deb;
      c_addr_rise: w_rd_data[W-1:0] = r_rise;
      c_addr_fall: w_rd_data[W-1:0] = r_fall;
      default:     w_rd_data[W-1:0] = r_mask;
    endcase
  end

  assign bus.rd_data = w_rd_data;
  assign bus.irq     = r_irq;

endmodule
`default_nettype wire
